fifo_write_arbiter: RTL and testbench

//  Shares the single write port of an async FIFO among NUM_REQ producers in the write clock domain.

---
 rtl/fifo_write_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-based arbiter sharing one async-FIFO write port among NUM_REQ producers.
// The FIFO full flag gates every beat combinationally, so nothing is presented while the FIFO is full.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    localparam int OW       = $clog2(NUM_REQ),
    localparam int BCW      = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    input  logic                      fifo_full,
    output logic                      fifo_write_enable,
    output logic [DATA_W-1:0]         fifo_write_data,
    output logic                      busy,
    output logic [OW-1:0]             owner
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic [OW-1:0]  owner_r;
    logic [OW-1:0]  owner_nxt_s;
    logic [BCW-1:0] beat_cnt_r;
    logic [BCW-1:0] beat_cnt_nxt_s;
    logic           owner_req_s;
    logic           burst_done_s;
    logic           beat_ok_s;

    // First requester after 'last' in circular order; 'last' itself is checked last.
    function automatic logic [OW-1:0] rr_pick(input logic [OW-1:0] last,
                                              input logic [NUM_REQ-1:0] r);
        logic [OW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && r[OW'(idx)]) begin
                pick  = OW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Owner-side qualifiers used by both the output and next-state logic.
    always_comb begin
        owner_req_s  = req[owner_r];
        burst_done_s = req_last[owner_r] || (beat_cnt_r == BCW'(MAX_BURST - 1));
        beat_ok_s    = !reset && (state_r == ST_BURST) && owner_req_s && !fifo_full;
    end

    // Beat acceptance and write-port drive; reset forces the port quiet in any state.
    always_comb begin
        ack = '0;
        if (beat_ok_s) begin
            ack[owner_r] = 1'b1;
        end else begin
            ack = '0;
        end
        fifo_write_enable = beat_ok_s;
        fifo_write_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_r == OW'(i)) begin
                fifo_write_data = req_data[i*DATA_W +: DATA_W];
            end else begin
                fifo_write_data = fifo_write_data;
            end
        end
        busy  = (state_r == ST_BURST);
        owner = owner_r;
    end

    // Next-state logic: arbitrate in IDLE, count/stall/terminate in BURST.
    always_comb begin
        state_nxt_s    = state_r;
        owner_nxt_s    = owner_r;
        beat_cnt_nxt_s = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    owner_nxt_s    = rr_pick(owner_r, req);
                    beat_cnt_nxt_s = '0;
                    state_nxt_s    = ST_BURST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!owner_req_s) begin
                    // Abandonment takes priority over a stall on full.
                    state_nxt_s    = ST_IDLE;
                    beat_cnt_nxt_s = '0;
                end else if (fifo_full) begin
                    beat_cnt_nxt_s = beat_cnt_r;
                end else if (burst_done_s) begin
                    state_nxt_s    = ST_IDLE;
                    beat_cnt_nxt_s = '0;
                end else begin
                    beat_cnt_nxt_s = beat_cnt_r + BCW'(1);
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                beat_cnt_nxt_s = '0;
            end
        endcase
    end

    // State registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= OW'(NUM_REQ - 1);
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            beat_cnt_r <= beat_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized bench for fifo_write_arbiter, checked against a behavioural
// model that tracks "who owns the port and how many beats they have written".
module tb_fifo_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    ack;
    logic            fifo_full;
    logic            fifo_write_enable;
    logic [DW-1:0]   fifo_write_data;
    logic            busy;
    logic [1:0]      owner;

    int n_checks = 0;
    int n_fail   = 0;

    bit            m_busy;
    int            m_owner;
    int            m_beats;
    logic [N-1:0]  last_exp_ack;
    logic [DW-1:0] wr_data_q[$];
    int            wr_own_q[$];

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk               (clk),
        .reset             (reset),
        .req               (req),
        .req_data          (req_data),
        .req_last          (req_last),
        .ack               (ack),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .busy              (busy),
        .owner             (owner)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: an owner writes while it requests and the FIFO has room, and gives up the
    // port after its last beat, after MB beats, or when it stops requesting.
    task automatic model_update();
        if (reset) begin
            m_busy  = 1'b0;
            m_owner = N - 1;
            m_beats = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (!m_busy && req[(m_owner + k) % N]) begin
                    m_owner = (m_owner + k) % N;
                    m_busy  = 1'b1;
                end
            end
            m_beats = 0;
        end else if (!req[m_owner]) begin
            m_busy  = 1'b0;
            m_beats = 0;
        end else if (!fifo_full) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MB) begin
                m_busy  = 1'b0;
                m_beats = 0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] e_ack;
        e_ack = '0;
        @(negedge clk);
        if (!reset && m_busy && req[m_owner] && !fifo_full) e_ack[m_owner] = 1'b1;
        check("ack", ack, e_ack);
        check("write_enable", fifo_write_enable, |e_ack);
        check("busy", busy, m_busy);
        check("owner", owner, m_owner);
        if (|e_ack) check("write_data", fifo_write_data, req_data[m_owner*DW +: DW]);
        if (fifo_write_enable === 1'b1) begin
            wr_data_q.push_back(fifo_write_data);
            wr_own_q.push_back(int'(owner));
        end
        last_exp_ack = e_ack;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_logs();
        wr_data_q.delete();
        wr_own_q.delete();
    endtask

    initial begin
        reset = 1'b1; req = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
        m_busy = 1'b0; m_owner = N - 1; m_beats = 0; last_exp_ack = '0;
        #1;

        // Reset with all requesting: port stays quiet
        req = 4'b1111;
        step(); step();

        // Single producer, three beats, last on the third
        reset = 1'b0;
        req = 4'b0001; req_data[7:0] = 8'hA1;
        step();
        check("first_owner_after_reset", owner, 64'd0);
        step();
        req_data[7:0] = 8'hA2; step();
        req_data[7:0] = 8'hA3; req_last[0] = 1'b1; step();
        req = '0; req_last = '0; step();
        check("t2_busy_done", busy, 64'd0);
        check("t2_write_count", wr_data_q.size(), 64'd3);
        if (wr_data_q.size() == 3) begin
            check("t2_data0", wr_data_q[0], 64'hA1);
            check("t2_data1", wr_data_q[1], 64'hA2);
            check("t2_data2", wr_data_q[2], 64'hA3);
        end

        // All requesting, no last: forced rotation after MB beats
        reset = 1'b1; step(); reset = 1'b0; clear_logs();
        req = 4'b1111; req_data = 32'h44332211;
        for (int s = 0; s < 5 * (MB + 1); s++) step();
        check("t3_write_count", wr_own_q.size(), 64'd20);
        if (wr_own_q.size() == 20) begin
            for (int w = 0; w < 20; w++) check("t3_grant_order", wr_own_q[w], (w / MB) % N);
        end
        req = '0; step();

        // Stall on full mid-burst by requester 2
        reset = 1'b1; step(); reset = 1'b0; clear_logs();
        req = 4'b0100; req_data[23:16] = 8'h5C;
        step(); step(); step();
        fifo_full = 1'b1; step(); step();
        check("t4_writes_before_resume", wr_own_q.size(), 64'd2);
        fifo_full = 1'b0; step(); step();
        check("t4_total_writes", wr_own_q.size(), 64'd4);
        check("t4_burst_over", busy, 64'd0);
        req = '0; step();

        // Requester 1 abandons after one beat, requester 3 waiting
        reset = 1'b1; step(); reset = 1'b0; clear_logs();
        req = 4'b0010; req_data[15:8] = 8'h77;
        step(); step();
        req = 4'b1000; req_data[31:24] = 8'h99;
        step();
        check("t5_abandon_idle", busy, 64'd0);
        step();
        check("t5_next_owner", owner, 64'd3);
        check("t5_busy", busy, 64'd1);
        req = '0; step(); step();

        // Reset mid-burst, then a fresh full burst for requester 2
        reset = 1'b1; step(); reset = 1'b0; clear_logs();
        req = 4'b0100; req_data[23:16] = 8'hC3;
        step(); step();
        reset = 1'b1; step();
        check("t6_writes_before_reset", wr_own_q.size(), 64'd1);
        reset = 1'b0; step();
        check("t6_owner_after_reset", owner, 64'd2);
        for (int s = 0; s < MB; s++) step();
        check("t6_total_writes", wr_own_q.size(), 64'd5);
        check("t6_burst_over", busy, 64'd0);
        req = '0; step();

        // Randomized traffic honouring the hold-until-ack producer rule
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ((req[i] && last_exp_ack[i]) || (!req[i] && $urandom_range(0, 99) < 40)) begin
                    req[i]               = ($urandom_range(0, 99) < 75);
                    req_data[i*DW +: DW] = DW'($urandom);
                    req_last[i]          = ($urandom_range(0, 99) < 30);
                end else if (req[i] && !last_exp_ack[i] && $urandom_range(0, 99) < 3) begin
                    req[i] = 1'b0;
                end
            end
            fifo_full = ($urandom_range(0, 99) < 25);
            reset     = ($urandom_range(0, 99) < 2);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
